// File: rtl/pipelined_cla_addsub.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 forms per-bit generate/propagate and 4-bit group lookahead terms;
// stage 2 resolves group carries as flat sum-of-products, expands them into
// bit carries and registers the result with its flags.
module pipelined_cla_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             Sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             C_out,
  output logic             Ovf,
  output logic             Zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NG = WIDTH / 4;

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: operand conditioning and group lookahead terms
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic             c0_in;
  logic [NG-1:0]    pg_in;
  logic [NG-1:0]    gg_in;

  // Subtraction is A + ~B + 1, so C_in is overridden by the forced carry.
  always_comb begin
    b_eff = Sub ? ~B : B;
    c0_in = Sub | C_in;
    p_in  = A ^ b_eff;
    g_in  = A & b_eff;
  end

  for (genvar gi = 0; gi < NG; gi++) begin : gen_grp_pg
    assign pg_in[gi] = &p_in[4*gi +: 4];
    assign gg_in[gi] = g_in[4*gi+3]
                     | (p_in[4*gi+3] & g_in[4*gi+2])
                     | (p_in[4*gi+3] & p_in[4*gi+2] & g_in[4*gi+1])
                     | (p_in[4*gi+3] & p_in[4*gi+2] & p_in[4*gi+1] & g_in[4*gi]);
  end

  // ---------------------------------------------------------------------------
  // Handshake: each stage advances when empty or when the stage after it drains
  // ---------------------------------------------------------------------------
  logic v1_q, v1_d;
  logic v2_q, v2_d;
  logic adv1, adv2;
  logic load1, load2;

  // Ready depends only on pipeline state and out_ready, never on in_valid.
  always_comb begin
    adv2     = ~v2_q | out_ready;
    adv1     = ~v1_q | adv2;
    in_ready = rst_n & adv1;
    load1    = in_valid & in_ready;
    load2    = adv2 & v1_q;
    v1_d     = adv1 ? in_valid : v1_q;
    v2_d     = adv2 ? v1_q : v2_q;
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] p1_q;
  logic [WIDTH-1:0] g1_q;
  logic [NG-1:0]    pg1_q;
  logic [NG-1:0]    gg1_q;
  logic             c01_q;
  logic             sub1_q;

  // Valid bits track occupancy; cleared asynchronously so nothing in flight survives reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end

  // Operand terms captured only on an actual transfer, otherwise held for a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q   <= '0;
      g1_q   <= '0;
      pg1_q  <= '0;
      gg1_q  <= '0;
      c01_q  <= 1'b0;
      sub1_q <= 1'b0;
    end else if (load1) begin
      p1_q   <= p_in;
      g1_q   <= g_in;
      pg1_q  <= pg_in;
      gg1_q  <= gg_in;
      c01_q  <= c0_in;
      sub1_q <= Sub;
    end
  end

  // The mode bit travels with its operands for observability; the result is
  // already fully determined by P, G and c0.
  logic sub_unused;
  assign sub_unused = sub1_q;

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: group carries, bit carries, sum and flags
  // ---------------------------------------------------------------------------
  logic [NG:0]    grp_c;
  logic [WIDTH:0] bit_c;
  logic [WIDTH-1:0] sum_d;
  logic           cout_d;
  logic           ovf_d;
  logic           zero_d;

  // Each group carry is a flat OR of product terms (GG[k] & PG[k+1..g], plus
  // c0 & PG[0..g]) so no group carry waits on the previous one.
  always_comb begin
    logic acc;
    logic term;
    grp_c    = '0;
    acc      = 1'b0;
    term     = 1'b0;
    grp_c[0] = c01_q;
    for (int g = 0; g < NG; g++) begin
      acc = c01_q;
      for (int k = 0; k <= g; k++) begin
        acc = acc & pg1_q[k];
      end
      for (int k = 0; k <= g; k++) begin
        term = gg1_q[k];
        for (int j = k + 1; j <= g; j++) begin
          term = term & pg1_q[j];
        end
        acc = acc | term;
      end
      grp_c[g+1] = acc;
    end
  end

  for (genvar gi = 0; gi < NG; gi++) begin : gen_bit_carry
    assign bit_c[4*gi]   = grp_c[gi];
    assign bit_c[4*gi+1] = g1_q[4*gi]
                         | (p1_q[4*gi] & grp_c[gi]);
    assign bit_c[4*gi+2] = g1_q[4*gi+1]
                         | (p1_q[4*gi+1] & g1_q[4*gi])
                         | (p1_q[4*gi+1] & p1_q[4*gi] & grp_c[gi]);
    assign bit_c[4*gi+3] = g1_q[4*gi+2]
                         | (p1_q[4*gi+2] & g1_q[4*gi+1])
                         | (p1_q[4*gi+2] & p1_q[4*gi+1] & g1_q[4*gi])
                         | (p1_q[4*gi+2] & p1_q[4*gi+1] & p1_q[4*gi] & grp_c[gi]);
  end
  assign bit_c[WIDTH] = grp_c[NG];

  // Result and flags derived from the resolved carry chain.
  always_comb begin
    sum_d  = p1_q ^ bit_c[WIDTH-1:0];
    cout_d = bit_c[WIDTH];
    ovf_d  = bit_c[WIDTH-1] ^ bit_c[WIDTH];
    zero_d = (sum_d == '0);
  end

  // ---------------------------------------------------------------------------
  // Stage 2 registers (module outputs)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  // Output register loads only when a valid stage-1 entry moves forward; held during stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (load2) begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign Sum       = sum_q;
  assign C_out     = cout_q;
  assign Ovf       = ovf_q;
  assign Zero      = zero_q;
  assign out_valid = v2_q;

endmodule
